ysyx_25020047_ifu: RTL and testbench
====================================

Name: ysyx_25020047_ifu

Overview:
Instruction fetch stage that sits directly upstream of the decode stage in the NPC core. It holds the architectural PC, issues one word-fetch request per instruction over a valid/ready memory request channel, and captures the response. It then presents the instruction and its PC to decode with a valid/ready handshake. It waits for the next-PC commit from the write-back/EXU path before fetching again. This gives a multi-cycle, one-instruction-in-flight fetch.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset; first fetch address.
XLEN, 32, width of PC, address and instruction buses.

Ports:
clk  input  1  core clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset (0 = reset asserted).
req_valid  output  1  fetch request valid.
req_ready  input  1  memory accepts request.
req_addr  output  XLEN  fetch address (word aligned).
rsp_valid  input  1  fetch response valid; single-cycle pulse.
rsp_data  input  XLEN  fetched instruction word.
rsp_err  input  1  access fault on this response.
inst_valid  output  1  instruction available to decode.
inst_ready  input  1  decode consumes instruction.
inst  output  XLEN  instruction word to decode.
pc  output  XLEN  PC of the presented instruction.
snpc  output  XLEN  pc + 4.
inst_fault  output  2  00 none, 01 access fault, 10 misaligned next PC.
dnpc_valid  input  1  commit of the next PC for the current instruction.
dnpc  input  XLEN  next PC from execute/write-back.
fetch_cnt  output  32  count of completed decode handshakes; wraps at 2^32.

Behaviour:
- Reset is asynchronous and active-low. While rst=0, all state is forced immediately: state=REQ, pc=RESET_PC, inst=0, inst_fault=00, fetch_cnt=0. Outputs while rst=0: req_valid=0, inst_valid=0. The first request appears on the first rising edge after rst is released; req_valid=1 is registered from REQ.
- FSM states: REQ, WAIT, VALID, WAIT_PC.
- REQ: req_valid=1, req_addr=pc.
  - req_valid&req_ready: go to WAIT.
  - Otherwise stay in REQ. req_addr is held stable while req_valid=1, and req_valid is never dropped before acceptance.
- WAIT: req_valid=0.
  - rsp_valid: inst<=rsp_data, inst_fault<=rsp_err?01:00, go to VALID.
  - rsp_valid in any other state is ignored.
- VALID: inst_valid=1. inst, pc, snpc and inst_fault are held stable until the handshake completes.
  - inst_valid&inst_ready: fetch_cnt<=fetch_cnt+1.
  - If dnpc_valid is also high in that same cycle, apply the dnpc rule below. Otherwise go to WAIT_PC.
  - dnpc_valid without inst_ready in VALID is ignored.
- WAIT_PC: inst_valid=0. On dnpc_valid, apply the dnpc rule.
- dnpc rule:
  - If dnpc[1:0]==00: pc<=dnpc, inst_fault<=00, go to REQ.
  - Otherwise: pc<=dnpc, inst<=0, inst_fault<=10, go to VALID with no memory request issued. A faulted slot still requires a decode handshake and counts in fetch_cnt.
- snpc = pc + 4, combinational, XLEN wrap (32'hFFFF_FFFC+4 = 0).
- Exactly one request is outstanding at a time, and there is no speculative fetch.
- Latency with req_ready=1 and a 1-cycle memory: REQ→WAIT 1 cycle, response +N cycles, VALID the cycle after rsp_valid.
- Reset asserted mid-transaction (WAIT/VALID) discards the in-flight request. A late rsp_valid after reset release arrives in REQ and is ignored.
- fetch_cnt wraps from 32'hFFFF_FFFF to 0 with no flag.

Test Plan:
- Reset then req_ready=1, 1-cycle mem returning 32'h00100093: req_addr=32'h8000_0000. Then inst_valid=1, inst=32'h00100093, pc=32'h8000_0000, snpc=32'h8000_0004.
- Backpressure: req_ready=0 for 5 cycles. req_valid stays 1 with req_addr stable. With inst_ready=0 for 3 cycles, inst and pc are held stable and fetch_cnt is unchanged until the handshake.
- inst_ready and dnpc_valid=1 with dnpc=32'h8000_0010 in the same cycle: next cycle state=REQ with req_addr=32'h8000_0010, and fetch_cnt increments by 1.
- dnpc=32'h8000_0002 in WAIT_PC: no req_valid. inst_valid=1, inst=0, inst_fault=10, pc=32'h8000_0002.
- rsp_err=1 with rsp_data=32'hDEADBEEF: inst=32'hDEADBEEF, inst_fault=01. A spurious rsp_valid in WAIT_PC causes no change.
- rst=0 pulse while in WAIT: outputs reset immediately (inst_valid=0, pc=32'h8000_0000). After release a fresh request goes to 32'h8000_0000, and fetch_cnt=0.

Source files
------------

// File: rtl/ysyx_25020047_ifu.sv
// Instruction fetch stage: one word fetch in flight, instruction handed to decode
// over valid/ready, then waits for the committed next PC before fetching again.
module ysyx_25020047_ifu #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [XLEN-1:0] rsp_data,
  input  logic            rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] snpc,
  output logic [1:0]      inst_fault,
  input  logic            dnpc_valid,
  input  logic [XLEN-1:0] dnpc,
  output logic [31:0]     fetch_cnt
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_VALID   = 2'd2,
    S_WAIT_PC = 2'd3
  } state_t;

  localparam logic [1:0] FAULT_NONE  = 2'b00;
  localparam logic [1:0] FAULT_ACCESS = 2'b01;
  localparam logic [1:0] FAULT_MISALIGN = 2'b10;

  state_t            r_state;
  logic              r_req_valid;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_inst;
  logic [1:0]        r_fault;
  logic [31:0]       r_cnt;

  state_t            w_state_next;
  logic [XLEN-1:0]   w_pc_next;
  logic [XLEN-1:0]   w_inst_next;
  logic [1:0]        w_fault_next;
  logic [31:0]       w_cnt_next;
  logic              w_dnpc_take;
  logic              w_req_fire;
  logic              w_inst_fire;

  assign w_req_fire  = r_req_valid & req_ready;
  assign w_inst_fire = (r_state == S_VALID) & inst_ready;

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_inst_next  = r_inst;
    w_fault_next = r_fault;
    w_cnt_next   = r_cnt;
    w_dnpc_take  = 1'b0;

    case (r_state)
      S_REQ: begin
        if (w_req_fire) begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rsp_valid) begin
          w_inst_next  = rsp_data;
          w_fault_next = rsp_err ? FAULT_ACCESS : FAULT_NONE;
          w_state_next = S_VALID;
        end
      end
      S_VALID: begin
        if (w_inst_fire) begin
          w_cnt_next = r_cnt + 32'd1;
          if (dnpc_valid) begin
            w_dnpc_take = 1'b1;
          end else begin
            w_state_next = S_WAIT_PC;
          end
        end
      end
      S_WAIT_PC: begin
        if (dnpc_valid) begin
          w_dnpc_take = 1'b1;
        end
      end
      default: begin
        w_state_next = S_REQ;
      end
    endcase

    // A misaligned target never reaches memory; it becomes a faulted slot for decode.
    if (w_dnpc_take) begin
      w_pc_next = dnpc;
      if (dnpc[1:0] == 2'b00) begin
        w_fault_next = FAULT_NONE;
        w_state_next = S_REQ;
      end else begin
        w_inst_next  = '0;
        w_fault_next = FAULT_MISALIGN;
        w_state_next = S_VALID;
      end
    end
  end

  // req_valid is registered so it stays low during reset and rises one edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_REQ;
      r_req_valid <= 1'b0;
      r_pc        <= RESET_PC;
      r_inst      <= '0;
      r_fault     <= FAULT_NONE;
      r_cnt       <= 32'd0;
    end else begin
      r_state     <= w_state_next;
      r_req_valid <= (w_state_next == S_REQ);
      r_pc        <= w_pc_next;
      r_inst      <= w_inst_next;
      r_fault     <= w_fault_next;
      r_cnt       <= w_cnt_next;
    end
  end

  assign req_valid  = r_req_valid;
  assign req_addr   = r_pc;
  assign inst_valid = (r_state == S_VALID);
  assign inst       = r_inst;
  assign pc         = r_pc;
  assign snpc       = r_pc + {{(XLEN-3){1'b0}}, 3'b100};
  assign inst_fault = r_fault;
  assign fetch_cnt  = r_cnt;

endmodule

// File: tb/tb_ysyx_25020047_ifu.sv
// Scoreboard bench for the fetch stage: expected decode slots are queued when the
// memory response (or a misaligned commit) is driven and checked at the handshake.
module tb_ysyx_25020047_ifu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        rsp_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] snpc;
  logic [1:0]  inst_fault;
  logic        dnpc_valid = 1'b0;
  logic [31:0] dnpc = '0;
  logic [31:0] fetch_cnt;

  ysyx_25020047_ifu #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .pc(pc), .snpc(snpc), .inst_fault(inst_fault),
    .dnpc_valid(dnpc_valid), .dnpc(dnpc), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  fault;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_req(input logic [31:0] addr, input int delay);
    int n;
    n = 0;
    while (!req_valid && n < 20) begin
      step();
      n++;
    end
    chk("req_seen", 32'(req_valid), 32'd1);
    chk("req_addr", req_addr, addr);
    for (int i = 0; i < delay; i++) begin
      step();
      chk("req_hold_valid", 32'(req_valid), 32'd1);
      chk("req_hold_addr", req_addr, addr);
    end
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    chk("req_drop", 32'(req_valid), 32'd0);
  endtask

  task automatic do_rsp(input logic [31:0] data, input logic err, input logic [31:0] addr, input int lat);
    exp_t e;
    for (int i = 0; i < lat; i++) begin
      chk("wait_no_valid", 32'(inst_valid), 32'd0);
      step();
    end
    rsp_valid = 1'b1;
    rsp_data  = data;
    rsp_err   = err;
    e.pc = addr;
    e.inst = data;
    e.fault = err ? 2'b01 : 2'b00;
    sb_q.push_back(e);
    step();
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    chk("valid_latency", 32'(inst_valid), 32'd1);
  endtask

  task automatic consume(input int stall, input logic dv, input logic [31:0] dn);
    exp_t e;
    e.pc = '0;
    e.inst = '0;
    e.fault = '0;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
    end
    chk("slot_inst", inst, e.inst);
    chk("slot_pc", pc, e.pc);
    chk("slot_snpc", snpc, e.pc + 32'd4);
    chk("slot_fault", 32'(inst_fault), 32'(e.fault));
    $display("txn pc=%h inst=%h fault=%0d cnt=%0d", pc, inst, inst_fault, fetch_cnt);
    // dnpc_valid is raised during the stall too; it must be ignored without inst_ready.
    dnpc_valid = dv;
    dnpc = dn;
    for (int i = 0; i < stall; i++) begin
      step();
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_inst", inst, e.inst);
      chk("stall_pc", pc, e.pc);
      chk("stall_cnt", fetch_cnt, exp_cnt);
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    dnpc_valid = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    chk("fetch_cnt", fetch_cnt, exp_cnt);
    chk("valid_drop", 32'(inst_valid), 32'd0);
  endtask

  task automatic commit(input logic [31:0] dn);
    exp_t e;
    dnpc_valid = 1'b1;
    dnpc = dn;
    step();
    dnpc_valid = 1'b0;
    if (dn[1:0] != 2'b00) begin
      e.pc = dn;
      e.inst = '0;
      e.fault = 2'b10;
      sb_q.push_back(e);
      chk("misalign_noreq", 32'(req_valid), 32'd0);
      chk("misalign_valid", 32'(inst_valid), 32'd1);
    end else begin
      chk("commit_req", 32'(req_valid), 32'd1);
      chk("commit_addr", req_addr, dn);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b0;
    #1;
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_inst", inst, 32'd0);
    chk("rst_fault", 32'(inst_fault), 32'd0);
    chk("rst_cnt", fetch_cnt, 32'd0);
    step();
    step();
    rst = 1'b1;
    chk("release_noreq", 32'(req_valid), 32'd0);

    // basic fetch, then commit sequential next PC
    do_req(32'h8000_0000, 0);
    do_rsp(32'h0010_0093, 1'b0, 32'h8000_0000, 1);
    consume(0, 1'b0, 32'h0);
    commit(32'h8000_0004);

    // request backpressure, decode stall, commit in the handshake cycle
    do_req(32'h8000_0004, 5);
    do_rsp(32'h0020_8113, 1'b0, 32'h8000_0004, 2);
    consume(3, 1'b1, 32'h8000_0010);
    chk("same_cycle_req", 32'(req_valid), 32'd1);
    chk("same_cycle_addr", req_addr, 32'h8000_0010);

    // misaligned next PC becomes a faulted slot without a memory request
    do_req(32'h8000_0010, 0);
    do_rsp(32'h0031_0193, 1'b0, 32'h8000_0010, 1);
    consume(0, 1'b0, 32'h0);
    commit(32'h8000_0002);
    consume(1, 1'b0, 32'h0);
    commit(32'h8000_0020);

    // access fault, then a spurious response in WAIT_PC
    do_req(32'h8000_0020, 0);
    do_rsp(32'hDEAD_BEEF, 1'b1, 32'h8000_0020, 1);
    consume(0, 1'b0, 32'h0);
    rsp_valid = 1'b1;
    rsp_data  = 32'h1234_5678;
    rsp_err   = 1'b1;
    step();
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    chk("spurious_valid", 32'(inst_valid), 32'd0);
    chk("spurious_req", 32'(req_valid), 32'd0);
    chk("spurious_cnt", fetch_cnt, exp_cnt);
    commit(32'h8000_0030);

    // reset while a request is in flight; a late response must be ignored
    do_req(32'h8000_0030, 0);
    rst = 1'b0;
    #1;
    chk("midrst_inst_valid", 32'(inst_valid), 32'd0);
    chk("midrst_req_valid", 32'(req_valid), 32'd0);
    chk("midrst_pc", pc, 32'h8000_0000);
    chk("midrst_cnt", fetch_cnt, 32'd0);
    chk("midrst_fault", 32'(inst_fault), 32'd0);
    exp_cnt = '0;
    @(negedge clk);
    rst = 1'b1;
    step();
    rsp_valid = 1'b1;
    rsp_data  = 32'hBAD0_BAD0;
    step();
    rsp_valid = 1'b0;
    chk("late_rsp_valid", 32'(inst_valid), 32'd0);
    chk("late_rsp_req", 32'(req_valid), 32'd1);
    do_req(32'h8000_0000, 0);
    do_rsp(32'h0010_0093, 1'b0, 32'h8000_0000, 1);
    consume(0, 1'b1, 32'h8000_0040);

    // snpc wraps at the top of the address space
    do_req(32'h8000_0040, 0);
    do_rsp(32'h0000_0013, 1'b0, 32'h8000_0040, 1);
    consume(0, 1'b1, 32'hFFFF_FFFC);
    do_req(32'hFFFF_FFFC, 0);
    do_rsp(32'h0000_0073, 1'b0, 32'hFFFF_FFFC, 1);
    consume(0, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
